// File: rtl/wb_ram_generic_data_pl_if.sv
// Bus bundle for the pipelined byte-enabled data array: an independent write
// port (we/din/waddr), a read request port (re/raddr) and the read result
// (dout/dout_valid/dout_uninit).
interface wb_ram_generic_data_pl_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 10
);
    logic [DW/8-1:0] we;
    logic [DW-1:0]   din;
    logic [AW-1:0]   waddr;
    logic            re;
    logic [AW-1:0]   raddr;
    logic [DW-1:0]   dout;
    logic            dout_valid;
    logic            dout_uninit;

    modport master (
        output we, din, waddr, re, raddr,
        input  dout, dout_valid, dout_uninit
    );

    modport slave (
        input  we, din, waddr, re, raddr,
        output dout, dout_valid, dout_uninit
    );
endinterface

// File: rtl/wb_ram_generic_data_pl.sv
// Pipelined, byte-enabled data array with independent read and write ports.
// Reads capture the array word in stage 0 and shift through READ_LATENCY-1
// further registers; dout holds its last value between reads.
// Optional macro WB_RAM_UNINIT_TRACK_EN keeps a written-word map and flags
// reads of never-written in-range words on dout_uninit (tied 0 otherwise).
module wb_ram_generic_data_pl #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 10,
    parameter int unsigned           DEPTH        = 1024,
    parameter int unsigned           READ_LATENCY = 1,
    parameter bit                    RDW_NEW      = 1'b1,
    parameter logic [DATA_WIDTH-1:0] FILL         = '0
) (
    input logic                       clk,
    input logic                       rst,
    wb_ram_generic_data_pl_if.slave   bus
);

    localparam int unsigned         NumLanes = DATA_WIDTH / 8;
    localparam int unsigned         IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_en;
    logic                  rd_in_range;
    logic                  same_addr;
    logic [IdxW-1:0]       widx;
    logic [IdxW-1:0]       ridx;
    logic [DATA_WIDTH-1:0] rd_merged;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_uninit;

    logic [READ_LATENCY-1:0] valid_q, valid_d;
    logic [READ_LATENCY-1:0] uninit_q, uninit_d;
    logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   data_d [READ_LATENCY];

    assign wr_en       = (|bus.we) && ({1'b0, bus.waddr} < DepthLim);
    assign rd_in_range = {1'b0, bus.raddr} < DepthLim;
    assign same_addr   = wr_en && (bus.waddr == bus.raddr);
    assign widx        = bus.waddr[IdxW-1:0];
    assign ridx        = bus.raddr[IdxW-1:0];

    // Array write: per-lane update, out-of-range writes dropped. No reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NumLanes; i++) begin
                if (bus.we[i]) begin
                    mem_q[widx][8*i +: 8] <= bus.din[8*i +: 8];
                end
            end
        end
    end

`ifdef WB_RAM_UNINIT_TRACK_EN
    logic [DEPTH-1:0] written_q;

    // Written-word map, cleared by reset, set by any in-range write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q <= '0;
        end else if (wr_en) begin
            written_q[widx] <= 1'b1;
        end
    end
`endif

    // Stage-0 read word, including read-during-write policy and FILL.
    always_comb begin
        rd_merged = mem_q[ridx];
        for (int i = 0; i < NumLanes; i++) begin
            if (bus.we[i]) begin
                rd_merged[8*i +: 8] = bus.din[8*i +: 8];
            end
        end
        rd_word   = FILL;
        rd_uninit = 1'b0;
        if (rd_in_range) begin
            rd_word = (RDW_NEW && same_addr) ? rd_merged : mem_q[ridx];
`ifdef WB_RAM_UNINIT_TRACK_EN
            // A same-cycle write only counts as written when new data is returned.
            rd_uninit = !(written_q[ridx] || (RDW_NEW && same_addr));
`endif
        end
    end

    // Read pipeline next state: empty stages keep their data so dout holds.
    always_comb begin
        valid_d     = {valid_q[READ_LATENCY-1:0]} << 1;
        valid_d[0]  = bus.re;
        uninit_d    = uninit_q;
        data_d      = data_q;
        if (bus.re) begin
            data_d[0]   = rd_word;
            uninit_d[0] = rd_uninit;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            if (valid_q[i-1]) begin
                data_d[i]   = data_q[i-1];
                uninit_d[i] = uninit_q[i-1];
            end
        end
    end

    // Read pipeline registers; reset discards every in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            uninit_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            uninit_q <= uninit_d;
            data_q   <= data_d;
        end
    end

    assign bus.dout        = data_q[READ_LATENCY-1];
    assign bus.dout_valid  = valid_q[READ_LATENCY-1];
    assign bus.dout_uninit = uninit_q[READ_LATENCY-1];

endmodule

// File: tb/tb_wb_ram_generic_data_pl.sv
// Scoreboard bench: two DUTs share one stimulus stream (A: latency 2, new data
// on same-address read/write; B: latency 4, old data). Expected results come
// from an array model and are queued per DUT; a negedge monitor pops and
// compares whenever a DUT raises dout_valid.
module tb_wb_ram_generic_data_pl;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1000;
    localparam int unsigned LAT_A = 2;
    localparam int unsigned LAT_B = 4;
    localparam logic [31:0] FILL  = 32'hF111_F111;

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        bit          uninit;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  we = '0;
    logic [31:0] din = '0;
    logic [9:0]  waddr = '0;
    logic        re = 1'b0;
    logic [9:0]  raddr = '0;
    int          cyc = 0;

    int checks = 0;
    int passes = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [31:0] mdl_mem [DEPTH];
    bit          mdl_ever [DEPTH];
    bit          mdl_map [DEPTH];

    wb_ram_generic_data_pl_if #(.DW(DW), .AW(AW)) bus_a ();
    wb_ram_generic_data_pl_if #(.DW(DW), .AW(AW)) bus_b ();

    assign bus_a.we = we;  assign bus_a.din = din;  assign bus_a.waddr = waddr;
    assign bus_a.re = re;  assign bus_a.raddr = raddr;
    assign bus_b.we = we;  assign bus_b.din = din;  assign bus_b.waddr = waddr;
    assign bus_b.re = re;  assign bus_b.raddr = raddr;

    wb_ram_generic_data_pl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(LAT_A),
        .RDW_NEW(1'b1), .FILL(FILL)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    wb_ram_generic_data_pl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(LAT_B),
        .RDW_NEW(1'b0), .FILL(FILL)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: every valid cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus_a.dout_valid) begin
                if (q_a.size() == 0) fail_now("a_spurious_valid");
                else begin
                    e = q_a.pop_front();
                    chk("a_latency", cyc, e.due);
                    if (e.chk_data) chk("a_data", bus_a.dout, e.data);
                    chk("a_uninit", {31'b0, bus_a.dout_uninit}, {31'b0, e.uninit});
                end
            end
            if (bus_b.dout_valid) begin
                if (q_b.size() == 0) fail_now("b_spurious_valid");
                else begin
                    e = q_b.pop_front();
                    chk("b_latency", cyc, e.due);
                    if (e.chk_data) chk("b_data", bus_b.dout, e.data);
                    chk("b_uninit", {31'b0, bus_b.dout_uninit}, {31'b0, e.uninit});
                end
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic bit track_en();
`ifdef WB_RAM_UNINIT_TRACK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // One cycle of stimulus; the model reads before it writes.
    task automatic drive(input logic [3:0] w_be, input logic [31:0] w_d, input int w_a,
                         input bit r_en, input int r_a);
        exp_t ea, eb;
        bit   same;
        we = w_be; din = w_d; waddr = 10'(w_a); re = r_en; raddr = 10'(r_a);
        if (r_en) begin
            ea.due = cyc + LAT_A;
            eb.due = cyc + LAT_B;
            if (r_a >= DEPTH) begin
                ea.data = FILL; ea.chk_data = 1'b1; ea.uninit = 1'b0;
                eb.data = FILL; eb.chk_data = 1'b1; eb.uninit = 1'b0;
            end else begin
                same = (w_be != 4'h0) && (w_a == r_a);
                ea.data     = same ? merge(mdl_mem[r_a], w_d, w_be) : mdl_mem[r_a];
                ea.chk_data = mdl_ever[r_a] || (same && w_be == 4'hF);
                ea.uninit   = track_en() && !(mdl_map[r_a] || same);
                eb.data     = mdl_mem[r_a];
                eb.chk_data = mdl_ever[r_a];
                eb.uninit   = track_en() && !mdl_map[r_a];
            end
            q_a.push_back(ea);
            q_b.push_back(eb);
        end
        if (w_be != 4'h0 && w_a < DEPTH) begin
            mdl_mem[w_a]  = merge(mdl_mem[w_a], w_d, w_be);
            mdl_ever[w_a] = 1'b1;
            mdl_map[w_a]  = 1'b1;
        end
        @(posedge clk);
        #1;
        we = '0; re = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        drive(be, d, a, 1'b0, 0);
    endtask

    task automatic rd(input int a);
        drive(4'h0, 32'h0, 0, 1'b1, a);
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
    endtask

    // Reset discards in-flight reads and clears the written map, not the array.
    task automatic do_reset();
        int seen = 0;
        rst = 1'b1;
        we = '0; re = 1'b0;
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < DEPTH; i++) mdl_map[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_dout", bus_a.dout, 32'h0);
        chk("rst_a_valid", {31'b0, bus_a.dout_valid}, 32'h0);
        chk("rst_a_uninit", {31'b0, bus_a.dout_uninit}, 32'h0);
        chk("rst_b_dout", bus_b.dout, 32'h0);
        chk("rst_b_valid", {31'b0, bus_b.dout_valid}, 32'h0);
        chk("rst_b_uninit", {31'b0, bus_b.dout_uninit}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_a.dout_valid || bus_b.dout_valid) seen++;
        end
        chk("no_valid_after_rst", seen, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(990, 1023));
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i] = '0; mdl_ever[i] = 1'b0; mdl_map[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // Full-word write then read.
        wr(5, 32'hDEAD_BEEF, 4'hF);
        rd(5);
        // Partial byte enables.
        wr(7, 32'h1122_3344, 4'hF);
        wr(7, 32'hAABB_CCDD, 4'b0101);
        rd(7);
        // Same-cycle read/write, then a plain read.
        wr(9, 32'h0, 4'hF);
        drive(4'hF, 32'h1234_5678, 9, 1'b1, 9);
        rd(9);
        // Back-to-back reads.
        for (int i = 0; i < 4; i++) wr(i, 32'hA0 + i, 4'hF);
        for (int i = 0; i < 4; i++) rd(i);
        drain();

        // Reset with two reads in flight; array contents survive.
        rd(0);
        rd(1);
        do_reset();
        rd(0);
        drain();

        // Written-word tracking and out-of-range reads.
        rd(100);
        wr(100, 32'h0000_0055, 4'b0001);
        rd(100);
        drain();
        do_reset();
        rd(100);
        rd(1023);
        rd(1000);
        rd(999);
        drain();

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            else drive(($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                       $urandom, rand_addr(),
                       $urandom_range(0, 9) < 7, rand_addr());
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
